// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
// Compile-time option: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
package program_loader_pkg;

  localparam int HEADER_BYTES   = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_LO = 3'd1;
  localparam state_t ST_LEN_HI = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_WRITE  = 3'd4;
  localparam state_t ST_CHECK  = 3'd5;
  localparam state_t ST_DONE   = 3'd6;
  localparam state_t ST_ERROR  = 3'd7;

endpackage

// File: rtl/loader_word_assembler.sv
// Collects stream bytes little-endian into a 32-bit word and flags the 4th byte.
// With PROGRAM_LOADER_CHECKSUM_EN it also keeps a running XOR of header and data bytes.
module loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        data_accept,
  input  logic [7:0]  byte_in,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  input  logic        sum_accept,
  output logic [7:0]  checksum,
`endif
  output logic [31:0] word_next,
  output logic        word_complete
);

  logic [31:0] word_q;
  logic [1:0]  byte_count;

  // word_next already contains the byte being accepted, so the top can register it directly
  always_comb begin
    word_next = word_q;
    word_next[8*byte_count +: 8] = byte_in;
  end

  assign word_complete = data_accept && (byte_count == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q     <= '0;
      byte_count <= '0;
    end else if (clear) begin
      word_q     <= '0;
      byte_count <= '0;
    end else if (data_accept) begin
      word_q     <= word_next;
      byte_count <= byte_count + 2'd1;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (clear) begin
      checksum <= '0;
    end else if (sum_accept) begin
      checksum <= checksum ^ byte_in;
    end
  end
`endif

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length header, writes little-endian words to instruction memory
// and releases the CPU once the image is complete. Option: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(DEFAULT_BASE_ADDRESS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_address_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [15:0]           words_loaded_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [15:0] DEPTH_LIMIT = 16'(MEMORY_DEPTH);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_value;
  logic [15:0] loaded_next;
  logic        accept;
  logic        start_load;
  logic [31:0] word_next;
  logic        word_complete;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  always_comb begin
    byte_ready_o = 1'b0;
    case (state)
      ST_LEN_LO, ST_LEN_HI, ST_DATA: byte_ready_o = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: byte_ready_o = 1'b1;
`endif
      default: byte_ready_o = 1'b0;
    endcase
  end

  assign accept      = byte_valid_i && byte_ready_o;
  assign start_load  = start_i && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign len_value   = {byte_i, len_lo};
  assign loaded_next = words_loaded_o + 16'd1;
  assign cpu_hold_o  = ~done_o;

  loader_word_assembler u_assembler (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_load),
    .data_accept  (accept && (state == ST_DATA)),
    .byte_in      (byte_i),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    .sum_accept   (accept && (state == ST_LEN_LO || state == ST_LEN_HI || state == ST_DATA)),
    .checksum     (checksum),
`endif
    .word_next    (word_next),
    .word_complete(word_complete)
  );

  // Write strobe is pulsed from DATA into WRITE so address/data are registered with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      wr_en_o        <= 1'b0;
      wr_address_o   <= BASE_ADDRESS;
      wr_data_o      <= '0;
      words_loaded_o <= '0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
      len_lo         <= '0;
      len            <= '0;
    end else begin
      wr_en_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) begin
            state          <= ST_LEN_LO;
            words_loaded_o <= '0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len_lo <= byte_i;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len <= len_value;
            if (len_value > DEPTH_LIMIT) begin
              state   <= ST_ERROR;
              error_o <= 1'b1;
            end else if (len_value == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state  <= ST_CHECK;
`else
              state  <= ST_DONE;
              done_o <= 1'b1;
`endif
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_complete) begin
            wr_en_o      <= 1'b1;
            wr_address_o <= BASE_ADDRESS + DATA_WIDTH'({words_loaded_o, 2'b00});
            wr_data_o    <= DATA_WIDTH'(word_next);
            state        <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          words_loaded_o <= loaded_next;
          if (loaded_next == len) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state  <= ST_CHECK;
`else
            state  <= ST_DONE;
            done_o <= 1'b1;
`endif
          end else begin
            state <= ST_DATA;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            if (byte_i == checksum) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state   <= ST_ERROR;
              error_o <= 1'b1;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed plan images plus random images
// compared against a byte-stream/word-list reference model.
module tb_program_loader;

  localparam int          MEMORY_DEPTH = 32;
  localparam logic [31:0] BASE         = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        wr_en_o;
  logic [31:0] wr_address_o;
  logic [31:0] wr_data_o;
  logic [15:0] words_loaded_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  time         wr_time_q[$];
  time         word_acc_q[$];

  program_loader #(.MEMORY_DEPTH(MEMORY_DEPTH), .DATA_WIDTH(32), .BASE_ADDRESS(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .byte_ready_o  (byte_ready_o),
    .wr_en_o       (wr_en_o),
    .wr_address_o  (wr_address_o),
    .wr_data_o     (wr_data_o),
    .words_loaded_o(words_loaded_o),
    .cpu_hold_o    (cpu_hold_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;

  // Every cycle with the strobe high is logged as a separate memory write
  always @(negedge clk) begin
    if (wr_en_o) begin
      wr_addr_q.push_back(wr_address_o);
      wr_data_q.push_back(wr_data_o);
      wr_time_q.push_back($time);
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_time_q.delete();
    word_acc_q.delete();
  endtask

  task automatic start_load();
    @(negedge clk);
    byte_valid_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap, output time acc_t, output bit ok);
    ok = 1'b0;
    acc_t = 0;
    repeat (gap) begin
      @(negedge clk);
      byte_valid_i = 1'b0;
    end
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      byte_i = b;
      byte_valid_i = 1'b1;
      if (byte_ready_o) begin
        @(posedge clk);
        acc_t = $time;
        ok = 1'b1;
      end
    end
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$], input int gap_mode, output time last_t);
    time t;
    bit  ok;
    int  gap;
    last_t = 0;
    foreach (bytes[i]) begin
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      drive_byte(bytes[i], gap, t, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL byte_accept idx %0d got not_accepted exp accepted", i);
        return;
      end
      if (i >= 2 && ((i - 2) % 4) == 3) word_acc_q.push_back(t);
      last_t = t;
    end
  endtask

  function automatic void build_image(input logic [31:0] words[$], output logic [7:0] bytes[$]);
    int n;
    n = words.size();
    bytes.delete();
    bytes.push_back(8'(n % 256));
    bytes.push_back(8'(n / 256));
    foreach (words[i])
      for (int k = 0; k < 4; k++) bytes.push_back(8'((words[i] >> (8 * k)) % 256));
  endfunction

  function automatic logic [7:0] stream_xor(input logic [7:0] bytes[$]);
    logic [7:0] x;
    x = 8'h00;
    foreach (bytes[i]) x = x ^ bytes[i];
    return x;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({byte_ready_o, wr_en_o, wr_address_o, wr_data_o, words_loaded_o, cpu_hold_o, done_o, error_o}
        !== {1'b0, 1'b0, BASE, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values got rdy=%b we=%b a=%h d=%h n=%0d hold=%b done=%b err=%b exp 0 0 %h 0 0 1 0 0",
               byte_ready_o, wr_en_o, wr_address_o, wr_data_o, words_loaded_o, cpu_hold_o, done_o, error_o, BASE);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_image(input string name, input logic [31:0] words[$], input int gap_mode);
    logic [7:0] bytes[$];
    time last_t, done_t, sum_t;
    bit  found, ok;
    int  n;
    n = words.size();
    clear_log();
    build_image(words, bytes);
    start_load();
    send_bytes(bytes, gap_mode, last_t);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    drive_byte(stream_xor(bytes), 0, sum_t, ok);
    if (!ok) sum_t = 0;
`else
    sum_t = 0;
    ok = 1'b1;
`endif
    found = 1'b0;
    done_t = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      byte_valid_i = 1'b0;
      if (done_o || error_o) begin
        found = 1'b1;
        done_t = $time;
        break;
      end
    end
    checks++;
    if (!found || !ok) begin
      errors++;
      $display("[TB] FAIL %s completion got timeout exp done", name);
    end
    checks++;
    if ({done_o, error_o, cpu_hold_o, byte_ready_o} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL %s flags got done=%b err=%b hold=%b rdy=%b exp 1 0 0 0",
               name, done_o, error_o, cpu_hold_o, byte_ready_o);
    end
    checks++;
    if (words_loaded_o !== 16'(n)) begin
      errors++;
      $display("[TB] FAIL %s words_loaded got %0d exp %0d", name, words_loaded_o, n);
    end
    checks++;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (done_t !== sum_t + 5) begin
      errors++;
      $display("[TB] FAIL %s done_timing got %0t exp %0t", name, done_t, sum_t + 5);
    end
`else
    if (done_t !== last_t + 15) begin
      errors++;
      $display("[TB] FAIL %s done_timing got %0t exp %0t", name, done_t, last_t + 15);
    end
`endif
    checks++;
    if (wr_addr_q.size() != n || word_acc_q.size() != n) begin
      errors++;
      $display("[TB] FAIL %s write_count got %0d exp %0d", name, wr_addr_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== words[i]) begin
          errors++;
          $display("[TB] FAIL %s write[%0d] got %h@%h exp %h@%h",
                   name, i, wr_data_q[i], wr_addr_q[i], words[i], BASE + 32'(4 * i));
        end
        checks++;
        if (wr_time_q[i] !== word_acc_q[i] + 5) begin
          errors++;
          $display("[TB] FAIL %s write_timing[%0d] got %0t exp %0t",
                   name, i, wr_time_q[i], word_acc_q[i] + 5);
        end
      end
    end
  endtask

  task automatic test_zero_length();
    logic [7:0] hdr[$];
    time last_t, t;
    bit  ok;
    clear_log();
    hdr = '{8'h00, 8'h00};
    start_load();
    send_bytes(hdr, 0, last_t);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    drive_byte(8'h00, 0, t, ok);
`else
    t = last_t;
    ok = 1'b1;
`endif
    @(negedge clk);
    byte_valid_i = 1'b0;
    checks++;
    if (!ok || {done_o, error_o, cpu_hold_o, words_loaded_o} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("[TB] FAIL zero_length got done=%b err=%b hold=%b n=%0d exp 1 0 0 0",
               done_o, error_o, cpu_hold_o, words_loaded_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_length_writes got %0d exp 0", wr_addr_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] hdr[$];
    time last_t;
    clear_log();
    hdr = '{8'h21, 8'h00};
    start_load();
    send_bytes(hdr, 0, last_t);
    @(negedge clk);
    byte_i = 8'hA5;
    checks++;
    if ({error_o, done_o, cpu_hold_o, byte_ready_o} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL overflow got err=%b done=%b hold=%b rdy=%b exp 1 0 1 0",
               error_o, done_o, cpu_hold_o, byte_ready_o);
    end
    repeat (6) @(negedge clk);
    byte_valid_i = 1'b0;
    checks++;
    if (wr_addr_q.size() != 0 || words_loaded_o !== 16'h0 || error_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_hold got writes=%0d n=%0d err=%b exp 0 0 1",
               wr_addr_q.size(), words_loaded_o, error_o);
    end
  endtask

  task automatic test_checksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] words[$];
    logic [7:0]  bytes[$];
    time last_t, t;
    bit  ok;
    clear_log();
    words = '{32'h2008000C, 32'h08000000};
    build_image(words, bytes);
    start_load();
    send_bytes(bytes, 0, last_t);
    drive_byte(8'h2F, 0, t, ok);
    @(negedge clk);
    byte_valid_i = 1'b0;
    checks++;
    if (!ok || {error_o, done_o, cpu_hold_o, byte_ready_o} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL bad_checksum got err=%b done=%b hold=%b rdy=%b exp 1 0 1 0",
               error_o, done_o, cpu_hold_o, byte_ready_o);
    end
    checks++;
    if (wr_addr_q.size() != 2 || words_loaded_o !== 16'd2) begin
      errors++;
      $display("[TB] FAIL bad_checksum_writes got %0d/%0d exp 2/2", wr_addr_q.size(), words_loaded_o);
    end
`endif
  endtask

  task automatic test_reset_midload();
    logic [31:0] words[$];
    logic [7:0]  bytes[$];
    time last_t;
    clear_log();
    words = '{32'h2008000C, 32'h08000000};
    build_image(words, bytes);
    bytes = bytes[0:7];
    start_load();
    send_bytes(bytes, 0, last_t);
    @(negedge clk);
    byte_valid_i = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({byte_ready_o, wr_en_o, wr_address_o, wr_data_o, words_loaded_o, cpu_hold_o, done_o, error_o}
        !== {1'b0, 1'b0, BASE, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midload_reset got rdy=%b we=%b a=%h d=%h n=%0d hold=%b done=%b err=%b exp reset values",
               byte_ready_o, wr_en_o, wr_address_o, wr_data_o, words_loaded_o, cpu_hold_o, done_o, error_o);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    byte_i = 8'h5A;
    byte_valid_i = 1'b1;
    repeat (10) @(negedge clk);
    byte_valid_i = 1'b0;
    checks++;
    if (wr_addr_q.size() != 1 || byte_ready_o !== 1'b0 || words_loaded_o !== 16'h0) begin
      errors++;
      $display("[TB] FAIL midload_after got writes=%0d rdy=%b n=%0d exp 1 0 0",
               wr_addr_q.size(), byte_ready_o, words_loaded_o);
    end
  endtask

  task automatic test_random(input string name, input int n, input int gap_mode);
    logic [31:0] words[$];
    for (int i = 0; i < n; i++) words.push_back($urandom);
    test_image(name, words, gap_mode);
  endtask

  initial begin
    logic [31:0] plan[$];
    plan = '{32'h2008000C, 32'h08000000};
    test_reset();
    test_image("plan_image", plan, 0);
    test_zero_length();
    test_overflow();
    test_image("toggle_valid", plan, 1);
    test_checksum();
    test_reset_midload();
    test_image("restart", plan, 0);
    test_random("random_a", int'($urandom_range(1, MEMORY_DEPTH)), 2);
    test_random("random_b", int'($urandom_range(1, MEMORY_DEPTH)), 2);
    test_random("back_to_back", int'($urandom_range(1, MEMORY_DEPTH)), 0);
    test_random("full_depth", MEMORY_DEPTH, 2);
    test_random("single_word", 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the instruction memory. Consumes a byte stream (header + little-endian words), assembles 32-bit instructions, and drives the write port of the program memory at MIPS text-segment byte addresses starting at 0x0040_0000. Holds the processor in reset until a complete, valid image is written. Sits between the host link (UART receiver) and the instruction-memory write port.

## Interface
- MEMORY_DEPTH, 32, number of instruction words the program memory holds
- DATA_WIDTH, 32, instruction/address width
- BASE_ADDRESS, 32'h0040_0000, byte address of the first word written
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start_i  in  1  pulse; begin a new load (sampled in IDLE, DONE, ERROR only)
- byte_i  in  8  incoming stream byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  loader accepts byte_i this cycle
- wr_en_o  out  1  one-cycle instruction-memory write strobe
- wr_address_o  out  DATA_WIDTH  byte address of word being written
- wr_data_o  out  DATA_WIDTH  assembled instruction
- words_loaded_o  out  16  count of words written in current load
- cpu_hold_o  out  1  keep processor in reset
- done_o  out  1  image loaded successfully (level)
- error_o  out  1  load aborted (level)

## Operation
- Stream: LEN_LO, LEN_HI (word count N, 16-bit little-endian), then 4*N data bytes, each word least-significant byte first.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK (macro only), DONE, ERROR.
- IDLE: start_i -> LEN_LO; clears words_loaded_o, byte counter, done_o, error_o.
- LEN_LO -> LEN_HI on accepted byte. LEN_HI on accepted byte: N > MEMORY_DEPTH -> ERROR; N = 0 -> CHECK (macro on) or DONE; else DATA.
- DATA: shift byte into assembly register at lane byte_count[1:0]; 4th byte -> WRITE.
- WRITE: wr_en_o = 1 for exactly one cycle, wr_address_o = BASE_ADDRESS + 4*words_loaded_o, wr_data_o = assembled word; words_loaded_o increments at end of cycle; if incremented value == N -> CHECK or DONE, else DATA.
- DONE: done_o = 1, cpu_hold_o = 0. ERROR: error_o = 1, cpu_hold_o = 1. start_i in either -> LEN_LO with flags cleared.
- start_i outside IDLE/DONE/ERROR ignored. Bytes offered in IDLE/DONE/ERROR are not accepted (byte_ready_o = 0).
- Address arithmetic modulo 2^DATA_WIDTH; words_loaded_o never exceeds MEMORY_DEPTH by construction.

## Timing
- Byte accepted on rising edge where byte_valid_i && byte_ready_o.
- byte_ready_o = 1 in LEN_LO, LEN_HI, DATA, CHECK; 0 in all other states.
- wr_en_o, wr_address_o, wr_data_o registered; asserted the cycle after the 4th byte is accepted. Peak throughput: 4 bytes per 5 cycles.
- done_o rises the cycle after the final WRITE (or after LEN_HI/CHECK when N = 0).
- Reset values: state IDLE, byte_ready_o 0, wr_en_o 0, wr_address_o BASE_ADDRESS, wr_data_o 0, words_loaded_o 0, cpu_hold_o 1, done_o 0, error_o 0.
- Reset mid-load: immediate return to reset values; partially assembled word is discarded, never written.
- byte_valid_i deasserted mid-word: state and partial word held indefinitely.

## Configuration
- PROGRAM_LOADER_CHECKSUM_EN defined: one trailing byte after the data (or after LEN_HI when N = 0), accepted in CHECK; must equal XOR of LEN_LO, LEN_HI and all data bytes. Match -> DONE, mismatch -> ERROR. Words already written remain in memory; cpu_hold_o stays 1.
- Undefined: no CHECK state, no trailing byte; last WRITE goes straight to DONE.

## Structure
- Package program_loader_pkg: state enum, HEADER_BYTES = 2, BYTES_PER_WORD = 4, default BASE_ADDRESS constant.
- One sub-module: loader_word_assembler (lane shift register, byte counter, word-complete flag, running XOR when macro on). FSM, address generation and flags in top.

## Test plan
- Reset, start_i, stream 02 00 | 0C 00 08 20 | 00 00 00 08 -> writes 0x2008000C @ 0x0040_0000, 0x08000000 @ 0x0040_0004; done_o = 1, cpu_hold_o = 0, words_loaded_o = 2.
- Header 00 00 -> no wr_en_o pulse, done_o = 1 next cycle (macro off).
- Header 21 00 with MEMORY_DEPTH = 32 -> error_o = 1, cpu_hold_o = 1, no writes, byte_ready_o = 0.
- Same image as test 1 with byte_valid_i toggled every other cycle -> identical writes/addresses, each write one cycle after 4th accepted byte.
- Macro on, image of test 1 plus checksum 0x2E -> done_o; checksum 0x2F -> error_o = 1.
- Assert reset after 6 data bytes -> all outputs at reset values, no further wr_en_o; restart with full image -> correct load.
